// File: rtl/snn_feeder.sv
// snn_feeder: streams image/kernel/weight ROM words into an SNN core and captures its result.
module snn_feeder #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  opt_in,
    input  logic        cg_en_in,
    output logic [6:0]  img_addr,
    input  logic [31:0] img_rdata,
    output logic [4:0]  ker_addr,
    input  logic [31:0] ker_rdata,
    output logic [1:0]  wgt_addr,
    input  logic [31:0] wgt_rdata,
    output logic        snn_in_valid,
    output logic [31:0] snn_img,
    output logic [31:0] snn_kernel,
    output logic [31:0] snn_weight,
    output logic [1:0]  snn_opt,
    output logic        snn_cg_en,
    input  logic        snn_out_valid,
    input  logic [31:0] snn_out,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, PREF, SEND, WAIT, DONE} state_t;
    state_t      state;
    logic [6:0]  beat;
    logic [6:0]  nk;
    logic [31:0] wait_cnt;
    logic [1:0]  opt_q;
    assign nk = beat + 7'd1;
    // Each address leads its beat by one cycle so the registered beat outputs line up with ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            wait_cnt     <= '0;
            opt_q        <= '0;
            img_addr     <= '0;
            ker_addr     <= '0;
            wgt_addr     <= '0;
            snn_in_valid <= 1'b0;
            snn_img      <= '0;
            snn_kernel   <= '0;
            snn_weight   <= '0;
            snn_opt      <= '0;
            snn_cg_en    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= PREF;
                    opt_q     <= opt_in;
                    snn_cg_en <= cg_en_in;
                    result    <= '0;
                    timeout   <= 1'b0;
                    busy      <= 1'b1;
                    img_addr  <= '0;
                    ker_addr  <= '0;
                    wgt_addr  <= '0;
                end
                PREF: begin
                    state        <= SEND;
                    beat         <= '0;
                    snn_in_valid <= 1'b1;
                    snn_img      <= img_rdata;
                    snn_kernel   <= ker_rdata;
                    snn_weight   <= wgt_rdata;
                    snn_opt      <= opt_q;
                    img_addr     <= 7'd1;
                    ker_addr     <= 5'd1;
                    wgt_addr     <= 2'd1;
                end
                SEND: if (beat == 7'd95) begin
                    state        <= WAIT;
                    wait_cnt     <= '0;
                    snn_in_valid <= 1'b0;
                    snn_img      <= '0;
                    snn_kernel   <= '0;
                    snn_weight   <= '0;
                    snn_opt      <= '0;
                end else begin
                    beat       <= nk;
                    snn_img    <= img_rdata;
                    snn_kernel <= nk < 7'd27 ? ker_rdata : '0;
                    snn_weight <= nk < 7'd4 ? wgt_rdata : '0;
                    snn_opt    <= '0;
                    img_addr   <= nk < 7'd95 ? nk + 7'd1 : 7'd95;
                    ker_addr   <= nk < 7'd26 ? nk[4:0] + 5'd1 : 5'd26;
                    wgt_addr   <= nk < 7'd3 ? nk[1:0] + 2'd1 : 2'd3;
                end
                WAIT: if (snn_out_valid) begin
                    result <= snn_out;
                    state  <= DONE;
                    done   <= 1'b1;
                end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                    state   <= DONE;
                    done    <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_feeder.sv
// tb_snn_feeder: randomized transactions against a per-cycle expectation model of the feeder.
module tb_snn_feeder;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cg_en_in = 1'b0, snn_out_valid = 1'b0;
    logic [1:0]  opt_in = '0;
    logic [31:0] snn_out = '0;
    logic [6:0]  img_addr;
    logic [4:0]  ker_addr;
    logic [1:0]  wgt_addr;
    logic [31:0] img_rdata, ker_rdata, wgt_rdata, snn_img, snn_kernel, snn_weight, result;
    logic [1:0]  snn_opt;
    logic        snn_in_valid, snn_cg_en, busy, done, timeout;
    logic [31:0] img_rom [96];
    logic [31:0] ker_rom [27];
    logic [31:0] wgt_rom [4];
    int n_checks = 0, n_fail = 0;

    snn_feeder dut (
        .clk(clk), .rst(rst), .start(start), .opt_in(opt_in), .cg_en_in(cg_en_in),
        .img_addr(img_addr), .img_rdata(img_rdata), .ker_addr(ker_addr), .ker_rdata(ker_rdata),
        .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata), .snn_in_valid(snn_in_valid),
        .snn_img(snn_img), .snn_kernel(snn_kernel), .snn_weight(snn_weight), .snn_opt(snn_opt),
        .snn_cg_en(snn_cg_en), .snn_out_valid(snn_out_valid), .snn_out(snn_out),
        .busy(busy), .done(done), .timeout(timeout), .result(result)
    );

    always #5 clk = ~clk;

    // ROMs read the registered address; the feeder's address register supplies the cycle of latency.
    assign img_rdata = img_addr < 7'd96 ? img_rom[img_addr] : 32'h0;
    assign ker_rdata = ker_addr < 5'd27 ? ker_rom[ker_addr] : 32'h0;
    assign wgt_rdata = wgt_rom[wgt_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_cleared();
        check("rst_busy", busy, 0);
        check("rst_valid", snn_in_valid, 0);
        check("rst_img", snn_img, 0);
        check("rst_kernel", snn_kernel, 0);
        check("rst_weight", snn_weight, 0);
        check("rst_opt", snn_opt, 0);
        check("rst_cg", snn_cg_en, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_ker_addr", ker_addr, 0);
        check("rst_wgt_addr", wgt_addr, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_result", result, 0);
    endtask

    // Start is sampled at edge 0; cycle c is the cycle after edge c-1. delay<0 means no response.
    task automatic run(input logic [1:0] opt, input logic cg, input int delay,
                       input logic [31:0] val, input bit noise, input int abort);
        int d, k, beats, pulses;
        bit hit;
        logic [31:0] exp_res;
        hit = delay >= 1 && delay <= 1000;
        d = hit ? 98 + delay : 1098;
        exp_res = hit ? val : 32'h0;
        beats = 0;
        pulses = 0;
        start = 1'b1;
        opt_in = opt;
        cg_en_in = cg;
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            snn_out_valid = 1'b0;
            snn_out = 32'h0;
            opt_in = 2'($urandom);
            cg_en_in = 1'($urandom);
            if (snn_in_valid) beats++;
            if (done) pulses++;
            if (c == 1) begin
                check("pref_busy", busy, 1);
                check("pref_valid", snn_in_valid, 0);
                check("pref_img_addr", img_addr, 0);
                check("pref_ker_addr", ker_addr, 0);
                check("pref_wgt_addr", wgt_addr, 0);
                check("start_clr_result", result, 0);
                check("start_clr_timeout", timeout, 0);
                check("pref_cg", snn_cg_en, cg);
            end else if (c <= 97) begin
                k = c - 2;
                check("beat_valid", snn_in_valid, 1);
                check("beat_img", snn_img, img_rom[k]);
                check("beat_kernel", snn_kernel, k < 27 ? ker_rom[k] : 32'h0);
                check("beat_weight", snn_weight, k < 4 ? wgt_rom[k] : 32'h0);
                check("beat_opt", snn_opt, k == 0 ? opt : 2'd0);
                check("beat_cg", snn_cg_en, cg);
                check("beat_img_addr", img_addr, k < 95 ? k + 1 : 95);
                check("beat_ker_addr", ker_addr, k < 26 ? k + 1 : 26);
                check("beat_wgt_addr", wgt_addr, k < 3 ? k + 1 : 3);
                check("beat_result", result, 0);
            end else if (c == 98) begin
                check("wait_valid", snn_in_valid, 0);
                check("wait_img", snn_img, 0);
                check("wait_kernel", snn_kernel, 0);
                check("wait_weight", snn_weight, 0);
                check("wait_opt", snn_opt, 0);
                check("wait_cg", snn_cg_en, cg);
                check("wait_busy", busy, 1);
            end
            if (c == d) begin
                check("done_pulse", done, 1);
                check("done_result", result, exp_res);
                check("done_timeout", timeout, !hit);
                check("done_cg", snn_cg_en, cg);
            end
            if (c == d + 1) begin
                check("idle_done", done, 0);
                check("idle_busy", busy, 0);
                check("beat_count", beats, 96);
                check("done_count", pulses, 1);
                check("hold_result", result, exp_res);
                check("hold_timeout", timeout, !hit);
            end
            if (hit && c == 97 + delay) begin
                snn_out_valid = 1'b1;
                snn_out = val;
            end
            if (noise && (c == 30 || c == 50)) begin
                start = 1'b1;
                snn_out_valid = 1'b1;
                snn_out = $urandom;
            end
            if (noise && c == d) start = 1'b1;
            if (abort >= 0 && c == 2 + abort) begin
                #2 rst = 1'b1;
                #1 check_cleared();
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                return;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 96; i++) img_rom[i] = i + 1;
        for (int i = 0; i < 27; i++) ker_rom[i] = i + 1;
        for (int i = 0; i < 4; i++) wgt_rom[i] = i + 1;
        repeat (3) @(negedge clk);
        check_cleared();
        rst = 1'b0;
        @(negedge clk);
        run(2'd2, 1'b0, 10, 32'hDEADBEEF, 1'b0, -1);
        run(2'd1, 1'b1, 5, 32'h0BADF00D, 1'b0, -1);
        run(2'd3, 1'b0, 7, 32'h12345678, 1'b1, -1);
        run(2'd3, 1'b1, 4, 32'h55AA55AA, 1'b0, 40);
        run(2'd2, 1'b0, 12, 32'hA5A5A5A5, 1'b0, -1);
        run(2'd1, 1'b1, -1, 32'h0, 1'b0, -1);
        run(2'd2, 1'b0, 1000, 32'hCAFEF00D, 1'b0, -1);
        run(2'd0, 1'b0, 1, 32'h13579BDF, 1'b0, -1);
        for (int i = 0; i < 96; i++) img_rom[i] = $urandom;
        for (int i = 0; i < 27; i++) ker_rom[i] = $urandom;
        for (int i = 0; i < 4; i++) wgt_rom[i] = $urandom;
        repeat (3) run(2'($urandom), 1'($urandom), int'($urandom_range(1, 40)), $urandom, 1'($urandom), -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snn_feeder.md
SNN_FEEDER -- requirements
Module: snn_feeder

Interface
REQ-001 Parameter TIMEOUT, default 1000, max cycles waited for snn_out_valid after the last input beat.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to run one SNN transaction.
REQ-005 opt_in  input  2  Opt value for the transaction, sampled with start.
REQ-006 cg_en_in  input  1  clock-gating enable, sampled with start.
REQ-007 img_addr / img_rdata  output 7 / input 32  image source ROM port, 96 words, 1-cycle read latency.
REQ-008 ker_addr / ker_rdata  output 5 / input 32  kernel source ROM port, 27 words, 1-cycle read latency.
REQ-009 wgt_addr / wgt_rdata  output 2 / input 32  weight source ROM port, 4 words, 1-cycle read latency.
REQ-010 snn_in_valid, snn_img, snn_kernel, snn_weight, snn_opt, snn_cg_en  output 1/32/32/32/2/1  drive the SNN input side.
REQ-011 snn_out_valid / snn_out  input 1 / 32  SNN result handshake.
REQ-012 busy, done, timeout  output 1 each  status; result  output 32  captured SNN output.

Function
REQ-013 FSM states IDLE, PREF, SEND, WAIT, DONE; encoding is free.
REQ-014 IDLE: start=1 -> PREF; opt_in and cg_en_in latched; result cleared to 0; timeout cleared to 0.
REQ-015 start is ignored in every state other than IDLE, including DONE.
REQ-016 PREF, one cycle: img_addr=0, ker_addr=0, wgt_addr=0 presented -> SEND.
REQ-017 SEND lasts exactly 96 cycles, beat index k=0..95; snn_in_valid=1 on each.
REQ-018 Beat k: snn_img = img_rdata (word k); img_addr = k+1 for k<95, held at 95 on k=95.
REQ-019 Beat k<27: snn_kernel = ker_rdata (word k); otherwise 0; ker_addr saturates at 26.
REQ-020 Beat k<4: snn_weight = wgt_rdata (word k); otherwise 0; wgt_addr saturates at 3.
REQ-021 snn_opt = latched opt on beat 0 only; otherwise 0.
REQ-022 snn_cg_en = latched cg_en at all times after start, including WAIT; 0 after reset.
REQ-023 Outside SEND: snn_in_valid=0; snn_img, snn_kernel, snn_weight and snn_opt are all 0.
REQ-024 After beat 95 -> WAIT; wait counter starts at 0 and increments each WAIT cycle.
REQ-025 WAIT with snn_out_valid=1: result <= snn_out -> DONE.
REQ-026 WAIT with counter = TIMEOUT-1 and no snn_out_valid: timeout <= 1, result stays 0 -> DONE.
REQ-027 If snn_out_valid and the timeout limit coincide, the capture wins: timeout stays 0.
REQ-028 snn_out_valid during IDLE, PREF, SEND or DONE is ignored and does not change result.
REQ-029 DONE, one cycle: done=1 -> IDLE; done is 0 in all other states.
REQ-030 result and timeout hold their values until the next accepted start.
REQ-031 busy=1 in PREF, SEND, WAIT and DONE; busy=0 in IDLE.
REQ-032 Latency, with start sampled at edge 0: first snn_in_valid in cycle 2, last in cycle 97, WAIT entered in cycle 98.
REQ-033 All outputs are registered; no combinational path from snn_out to result.

Reset
REQ-034 rst=1 forces IDLE immediately, asynchronously, from any state including mid-SEND.
REQ-035 rst=1 sets all outputs and addresses to 0 and clears the latched opt and cg_en.
REQ-036 A transaction interrupted by reset is abandoned; no done pulse is produced for it.
REQ-037 Operation resumes on the first clk edge after rst deasserts.

Verification
REQ-038 Nominal run: ROM word i = i+1, opt_in=2, start; SNN model returns 0xDEADBEEF 10 cycles after the last beat -> 96 in_valid beats, img 1..96, kernel 1..27 then 0, weight 1..4 then 0, opt=2 on beat 0 only; done pulses; result=0xDEADBEEF; timeout=0.
REQ-039 Timeout: SNN model never responds, TIMEOUT=1000 -> done exactly 1000 cycles after WAIT entry; timeout=1; result=0.
REQ-040 Ignored inputs: start pulses during SEND and in the DONE cycle, plus spurious snn_out_valid during SEND -> no restart, beat count remains 96, result unaffected.
REQ-041 Reset mid-SEND at beat 40 -> all outputs 0 asynchronously; no done pulse; a fresh start afterwards gives a clean 96-beat run.
REQ-042 Back-to-back runs: second start in the cycle after done with opt_in=1, cg_en_in=1 -> result and timeout cleared at that start; snn_cg_en=1 throughout; beat-0 opt=1.
REQ-043 Coincidence: snn_out_valid=1 exactly on wait counter TIMEOUT-1 -> result captured; timeout=0.
